gumnut_datapath_mc: RTL and testbench
=====================================

# gumnut_datapath_mc

Parametrised successor to the Gumnut execute datapath: register file, operand mux, ALU, carry/zero flag register and 4-way writeback mux, generalised in data width and register count. Adds an iterative shift-add multiply unit with a start/busy/done handshake that writes its result back autonomously. Sits between the instruction decoder/control FSM and the data-memory/port buses; the decoder supplies register addresses and the immediate already extracted.

## Interface
- DW, 8, data width in bits (>= 4)
- NREG, 8, register count (power of 2, >= 2); RA = $clog2(NREG), CW = $clog2(DW)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- en_i  in  1  clock enable; low freezes every register including the multiplier
- reg_wr_i  in  1  register-file write strobe
- flag_wr_i  in  1  flag-register update strobe
- wb_sel_i  in  2  writeback source: 00 ALU, 01 data_dat_i, 10 port_dat_i, 11 no write
- op2_sel_i  in  1  1 = rs2 register, 0 = immed_i
- alu_op_i  in  4  ALU function
- rs_addr_i, rs2_addr_i, rd_addr_i  in  RA  register addresses
- immed_i  in  DW  immediate operand
- count_i  in  CW  shift/rotate amount
- data_dat_i, port_dat_i  in  DW  load sources
- mul_start_i  in  1  start multiply of rs × op2 into rd
- mul_busy_o  out  1  multiplier active
- mul_done_o  out  1  one-cycle pulse at multiplier writeback
- rs_o  out  DW  rs read data (store data / address base)
- res_o  out  DW  ALU result (combinational)
- carry_o, zero_o  out  1  registered flags

## Operation
- Register file: NREG × DW, combinational reads; r0 always reads 0, writes to r0 discarded. Write when en_i & reg_wr_i & wb_sel_i != 11.
- ALU (op2 = mux(op2_sel_i)): 0000 add, 0001 add+carry_o, 0010 sub, 0011 sub−carry_o, 0100 and, 0101 or, 0110 xor, 0111 rs & ~op2, 1000 shl, 1001 shr, 1010 rol, 1011 ror by count_i; 1100–1111 res = 0.
- Carry: add = bit DW of DW+1-bit sum; sub = borrow (rs < op2 + cin unsigned); shl/shr = last bit shifted out, 0 when count_i = 0; logic, rotate, unused ops = 0. Zero = (res == 0).
- Flags load ALU carry/zero when en_i & flag_wr_i.
- Multiplier FSM IDLE → BUSY → DONE → IDLE. In IDLE with en_i & mul_start_i: latch rs, op2, rd_addr_i, clear 2·DW accumulator, counter = DW. BUSY: one multiplier bit per enabled cycle, DW cycles. DONE (one cycle): write low DW bits to latched rd (r0 discarded), carry ← (high half != 0), zero ← (low half == 0), mul_done_o = 1.
- mul_start_i outside IDLE ignored. mul_busy_o = 1 in BUSY and DONE.
- DONE writeback has priority: a same-cycle reg_wr_i/flag_wr_i is dropped; controller holds while mul_busy_o. Reads of the rd under multiplication return the old value until DONE.

## Timing
- Reset (rst_i low, async): all registers 0, carry_o = zero_o = 0, FSM IDLE, mul_busy_o = mul_done_o = 0. Reset mid-multiply aborts; no writeback.
- res_o, rs_o: combinational, same cycle as addresses.
- Register/flag write visible on reads the cycle after the write edge (no bypass).
- Multiply latency: start edge → mul_done_o high DW+1 cycles later (with en_i held high); result readable the cycle after done. en_i low stretches latency cycle-for-cycle, mul_done_o held until an enabled edge.

## Test plan
- Reset: after rst_i low, all reg reads 0, carry_o/zero_o 0; write 0xAA to r0 -> reads 0.
- DW=8: r1=0xF0, r2=0x20, add flag_wr -> res 0x10, carry 1, zero 0; addc r0+r0 -> res 0x01; sub r2−r1 -> 0x30, carry 1.
- shl r1 count 4 -> 0x00, carry 1 (last bit out), zero 1; count 0 -> 0xF0, carry 0; ror 0x81 by 1 -> 0xC0.
- Multiply r3 = 0x12 × 0x10: busy 8 cycles, mul_done_o pulse cycle 9, r3 = 0x20, carry 1; 0x03 × 0x05 -> 0x0F, carry 0.
- Concurrency: mul_start_i during BUSY ignored; reg_wr_i in DONE cycle dropped; en_i low 3 cycles -> done 3 cycles later; rst_i mid-multiply -> rd unchanged.
- Parameter sweep DW=16, NREG=16: 0xFFFF+1 -> 0x0000, carry 1, zero 1; multiply 0x0100×0x0100 -> 0x0000, carry 1, zero 1.

Source files
------------

// File: rtl/gumnut_datapath_mc.sv
// Gumnut execute datapath: register file, operand mux, ALU, carry/zero flags,
// writeback mux, plus an iterative shift-add multiplier that writes back on its own.
module gumnut_datapath_mc #(
    parameter int  DW   = 8,
    parameter int  NREG = 8,
    localparam int RA   = $clog2(NREG),
    localparam int CW   = $clog2(DW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          reg_wr_i,
    input  logic          flag_wr_i,
    input  logic [1:0]    wb_sel_i,
    input  logic          op2_sel_i,
    input  logic [3:0]    alu_op_i,
    input  logic [RA-1:0] rs_addr_i,
    input  logic [RA-1:0] rs2_addr_i,
    input  logic [RA-1:0] rd_addr_i,
    input  logic [DW-1:0] immed_i,
    input  logic [CW-1:0] count_i,
    input  logic [DW-1:0] data_dat_i,
    input  logic [DW-1:0] port_dat_i,
    input  logic          mul_start_i,
    output logic          mul_busy_o,
    output logic          mul_done_o,
    output logic [DW-1:0] rs_o,
    output logic [DW-1:0] res_o,
    output logic          carry_o,
    output logic          zero_o
);

    // Multiplier FSM
    // state  | meaning
    // S_IDLE | waiting for mul_start_i; operands latched on start
    // S_BUSY | one multiplier bit consumed per enabled cycle, DW cycles
    // S_DONE | product low half written to latched rd, flags updated
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

    localparam int CNTW = $clog2(DW + 1);

    mul_state_e          state_q, state_d;
    logic [DW-1:0]       regs_q [NREG];
    logic [DW-1:0]       regs_d [NREG];
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic [2*DW-1:0]     acc_q, acc_d;
    logic [2*DW-1:0]     mcand_q, mcand_d;
    logic [DW-1:0]       mplier_q, mplier_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [RA-1:0]       mrd_q, mrd_d;

    logic [DW-1:0]       rs_val, rs2_val, op2, res, wb_data;
    logic                alu_c;
    logic [DW:0]         sum_ext;
    logic [2*DW-1:0]     sh_wide;

    assign rs_val  = (rs_addr_i  == '0) ? '0 : regs_q[rs_addr_i];
    assign rs2_val = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
    assign op2     = op2_sel_i ? rs2_val : immed_i;

    always_comb begin
        res     = '0;
        alu_c   = 1'b0;
        sum_ext = '0;
        sh_wide = '0;
        case (alu_op_i)
            4'h0: begin
                sum_ext = {1'b0, rs_val} + {1'b0, op2};
                res     = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            4'h1: begin
                sum_ext = {1'b0, rs_val} + {1'b0, op2} + {{DW{1'b0}}, carry_q};
                res     = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            // Bit DW of the widened difference is the unsigned borrow.
            4'h2: begin
                sum_ext = {1'b0, rs_val} - {1'b0, op2};
                res     = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            4'h3: begin
                sum_ext = {1'b0, rs_val} - {1'b0, op2} - {{DW{1'b0}}, carry_q};
                res     = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            4'h4: res = rs_val & op2;
            4'h5: res = rs_val | op2;
            4'h6: res = rs_val ^ op2;
            4'h7: res = rs_val & ~op2;
            4'h8: begin
                sh_wide = {{DW{1'b0}}, rs_val} << count_i;
                res     = sh_wide[DW-1:0];
                alu_c   = sh_wide[DW];
            end
            4'h9: begin
                sh_wide = {rs_val, {DW{1'b0}}} >> count_i;
                res     = sh_wide[2*DW-1:DW];
                alu_c   = sh_wide[DW-1];
            end
            4'hA: begin
                sh_wide = {rs_val, rs_val} << count_i;
                res     = sh_wide[2*DW-1:DW];
            end
            4'hB: begin
                sh_wide = {rs_val, rs_val} >> count_i;
                res     = sh_wide[DW-1:0];
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        case (wb_sel_i)
            2'b01:   wb_data = data_dat_i;
            2'b10:   wb_data = port_dat_i;
            default: wb_data = res;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        mrd_d    = mrd_q;
        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (mul_start_i) begin
                        acc_d    = '0;
                        mcand_d  = {{DW{1'b0}}, rs_val};
                        mplier_d = op2;
                        cnt_d    = CNTW'(DW);
                        mrd_d    = rd_addr_i;
                        state_d  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Multiplier writeback pre-empts any controller write in the DONE cycle.
    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (en_i) begin
            if (state_q == S_DONE) begin
                if (mrd_q != '0) begin
                    regs_d[mrd_q] = acc_q[DW-1:0];
                end
                carry_d = |acc_q[2*DW-1:DW];
                zero_d  = (acc_q[DW-1:0] == '0);
            end else begin
                if (reg_wr_i && (wb_sel_i != 2'b11) && (rd_addr_i != '0)) begin
                    regs_d[rd_addr_i] = wb_data;
                end
                if (flag_wr_i) begin
                    carry_d = alu_c;
                    zero_d  = (res == '0);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            regs_q   <= '{default: '0};
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mrd_q    <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            mrd_q    <= mrd_d;
        end
    end

    assign rs_o       = rs_val;
    assign res_o      = res;
    assign carry_o    = carry_q;
    assign zero_o     = zero_q;
    assign mul_busy_o = (state_q != S_IDLE);
    assign mul_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_gumnut_datapath_mc.sv
// Directed bench for gumnut_datapath_mc: an 8-bit/8-register instance and a
// 16-bit/16-register instance driven by one linear sequence of steps.
module tb_gumnut_datapath_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       en, reg_wr, flag_wr, op2_sel, mul_start;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic [2:0] rs_a, rs2_a, rd_a, count;
    logic [7:0] immed, data_dat, port_dat;
    logic       busy, done, carry, zero;
    logic [7:0] rs_o, res_o;

    logic        en_w, reg_wr_w, flag_wr_w, op2_sel_w, mul_start_w;
    logic [1:0]  wb_sel_w;
    logic [3:0]  alu_op_w;
    logic [3:0]  rs_a_w, rs2_a_w, rd_a_w, count_w;
    logic [15:0] immed_w, data_dat_w, port_dat_w;
    logic        busy_w, done_w, carry_w, zero_w;
    logic [15:0] rs_o_w, res_o_w;

    int n_vec = 0;
    int n_err = 0;
    logic seen_done;

    gumnut_datapath_mc #(.DW(8), .NREG(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .reg_wr_i(reg_wr), .flag_wr_i(flag_wr),
        .wb_sel_i(wb_sel), .op2_sel_i(op2_sel), .alu_op_i(alu_op),
        .rs_addr_i(rs_a), .rs2_addr_i(rs2_a), .rd_addr_i(rd_a), .immed_i(immed),
        .count_i(count), .data_dat_i(data_dat), .port_dat_i(port_dat),
        .mul_start_i(mul_start), .mul_busy_o(busy), .mul_done_o(done),
        .rs_o(rs_o), .res_o(res_o), .carry_o(carry), .zero_o(zero)
    );

    gumnut_datapath_mc #(.DW(16), .NREG(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst_n), .en_i(en_w), .reg_wr_i(reg_wr_w), .flag_wr_i(flag_wr_w),
        .wb_sel_i(wb_sel_w), .op2_sel_i(op2_sel_w), .alu_op_i(alu_op_w),
        .rs_addr_i(rs_a_w), .rs2_addr_i(rs2_a_w), .rd_addr_i(rd_a_w), .immed_i(immed_w),
        .count_i(count_w), .data_dat_i(data_dat_w), .port_dat_i(port_dat_w),
        .mul_start_i(mul_start_w), .mul_busy_o(busy_w), .mul_done_o(done_w),
        .rs_o(rs_o_w), .res_o(res_o_w), .carry_o(carry_w), .zero_o(zero_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [2:0] r, input logic [7:0] v);
        rd_a = r; data_dat = v; wb_sel = 2'b01; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic rd8(input string tag, input logic [2:0] r, input logic [7:0] exp);
        rs_a = r;
        #1;
        chk(tag, {24'd0, rs_o}, {24'd0, exp});
    endtask

    task automatic alu8(input string tag, input logic [3:0] op, input logic [2:0] ra,
                        input logic sel, input logic [2:0] rb, input logic [7:0] imm,
                        input logic [2:0] cnt, input logic [7:0] exp);
        alu_op = op; rs_a = ra; op2_sel = sel; rs2_a = rb; immed = imm; count = cnt;
        #1;
        chk(tag, {24'd0, res_o}, {24'd0, exp});
    endtask

    task automatic flags8(input string tag, input logic c, input logic z);
        flag_wr = 1'b1;
        tick();
        flag_wr = 1'b0;
        chk({tag, "_c"}, {31'd0, carry}, {31'd0, c});
        chk({tag, "_z"}, {31'd0, zero}, {31'd0, z});
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1; reg_wr = 1'b0; flag_wr = 1'b0; op2_sel = 1'b0; mul_start = 1'b0;
        wb_sel = 2'b00; alu_op = 4'h0; rs_a = '0; rs2_a = '0; rd_a = '0; count = '0;
        immed = '0; data_dat = '0; port_dat = '0;
        en_w = 1'b1; reg_wr_w = 1'b0; flag_wr_w = 1'b0; op2_sel_w = 1'b0; mul_start_w = 1'b0;
        wb_sel_w = 2'b00; alu_op_w = 4'h0; rs_a_w = '0; rs2_a_w = '0; rd_a_w = '0;
        count_w = '0; immed_w = '0; data_dat_w = '0; port_dat_w = '0;
        tick(); tick();

        // Reset state
        for (int r = 0; r < 8; r++) rd8("rst_reg", 3'(r), 8'h00);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        load8(3'd0, 8'hAA);
        rd8("r0_discard", 3'd0, 8'h00);
        load8(3'd1, 8'hF0);
        rd_a = 3'd2; port_dat = 8'h20; wb_sel = 2'b10; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
        rd8("r1_load", 3'd1, 8'hF0);
        rd8("r2_port", 3'd2, 8'h20);

        // ALU and flags
        alu8("add", 4'h0, 3'd1, 1'b1, 3'd2, 8'h00, 3'd0, 8'h10);
        flags8("add", 1'b1, 1'b0);
        alu8("addc", 4'h1, 3'd0, 1'b1, 3'd0, 8'h00, 3'd0, 8'h01);
        alu8("sub", 4'h2, 3'd2, 1'b1, 3'd1, 8'h00, 3'd0, 8'h30);
        flags8("sub", 1'b1, 1'b0);
        alu8("subc", 4'h3, 3'd2, 1'b1, 3'd1, 8'h00, 3'd0, 8'h2F);
        alu8("andn", 4'h7, 3'd1, 1'b1, 3'd2, 8'h00, 3'd0, 8'hD0);
        alu8("or_imm", 4'h5, 3'd1, 1'b0, 3'd0, 8'h0C, 3'd0, 8'hFC);
        alu8("unused", 4'hC, 3'd1, 1'b1, 3'd2, 8'h00, 3'd0, 8'h00);
        alu8("shl4", 4'h8, 3'd1, 1'b0, 3'd0, 8'h00, 3'd4, 8'h00);
        flags8("shl4", 1'b1, 1'b1);
        alu8("shl0", 4'h8, 3'd1, 1'b0, 3'd0, 8'h00, 3'd0, 8'hF0);
        flags8("shl0", 1'b0, 1'b0);
        load8(3'd4, 8'h81);
        alu8("ror1", 4'hB, 3'd4, 1'b0, 3'd0, 8'h00, 3'd1, 8'hC0);
        alu8("rol1", 4'hA, 3'd4, 1'b0, 3'd0, 8'h00, 3'd1, 8'h03);
        alu8("shr1", 4'h9, 3'd4, 1'b0, 3'd0, 8'h00, 3'd1, 8'h40);
        flags8("shr1", 1'b1, 1'b0);

        rd_a = 3'd5; data_dat = 8'h99; wb_sel = 2'b11; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
        rd8("wb11_nowrite", 3'd5, 8'h00);

        // Multiply 0x12 x 0x10 into r3; a second start while busy is ignored
        load8(3'd6, 8'h12);
        load8(3'd3, 8'h77);
        rs_a = 3'd6; op2_sel = 1'b0; immed = 8'h10; rd_a = 3'd3; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("mul1_busy", {31'd0, busy}, 32'd1);
            chk("mul1_nodone", {31'd0, done}, 32'd0);
            if (k == 3) begin
                rs_a = 3'd1; immed = 8'hFF; rd_a = 3'd5; mul_start = 1'b1;
            end else begin
                mul_start = 1'b0;
            end
            tick();
        end
        chk("mul1_done", {31'd0, done}, 32'd1);
        chk("mul1_busy_done", {31'd0, busy}, 32'd1);
        rd8("mul1_old_rd", 3'd3, 8'h77);
        rd_a = 3'd3; data_dat = 8'h55; wb_sel = 2'b01; reg_wr = 1'b1;
        alu_op = 4'h0; rs_a = 3'd0; op2_sel = 1'b0; immed = 8'h00; flag_wr = 1'b1;
        tick();
        reg_wr = 1'b0; flag_wr = 1'b0;
        chk("mul1_done_clr", {31'd0, done}, 32'd0);
        chk("mul1_idle", {31'd0, busy}, 32'd0);
        rd8("mul1_result", 3'd3, 8'h20);
        rd8("mul1_ignored_rd", 3'd5, 8'h00);
        chk("mul1_carry", {31'd0, carry}, 32'd1);
        chk("mul1_zero", {31'd0, zero}, 32'd0);

        // Multiply 0x03 x 0x05 into r7 with en low for 3 cycles mid-run
        load8(3'd5, 8'h03);
        rs_a = 3'd5; op2_sel = 1'b0; immed = 8'h05; rd_a = 3'd7; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            tick();
            chk("mul2_done_at", {31'd0, done}, {31'd0, (k == 11)});
        end
        en = 1'b0;
        tick();
        chk("mul2_done_held", {31'd0, done}, 32'd1);
        rd8("mul2_old_rd", 3'd7, 8'h00);
        en = 1'b1;
        tick();
        chk("mul2_done_clr", {31'd0, done}, 32'd0);
        rd8("mul2_result", 3'd7, 8'h0F);
        chk("mul2_carry", {31'd0, carry}, 32'd0);
        chk("mul2_zero", {31'd0, zero}, 32'd0);

        // Reset mid-multiply aborts without writeback
        rs_a = 3'd6; op2_sel = 1'b0; immed = 8'h02; rd_a = 3'd4; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        rd8("abort_rd", 3'd4, 8'h00);

        // 16-bit, 16-register instance
        rd_a_w = 4'd1; data_dat_w = 16'hFFFF; wb_sel_w = 2'b01; reg_wr_w = 1'b1;
        tick();
        rd_a_w = 4'd9; port_dat_w = 16'h0100; wb_sel_w = 2'b10;
        tick();
        rd_a_w = 4'd10; data_dat_w = 16'h1234; wb_sel_w = 2'b01;
        tick();
        reg_wr_w = 1'b0;
        rs_a_w = 4'd1; op2_sel_w = 1'b0; immed_w = 16'h0001; alu_op_w = 4'h0;
        #1;
        chk("w_add_res", {16'd0, res_o_w}, 32'h0000);
        flag_wr_w = 1'b1;
        tick();
        flag_wr_w = 1'b0;
        chk("w_add_carry", {31'd0, carry_w}, 32'd1);
        chk("w_add_zero", {31'd0, zero_w}, 32'd1);
        rs_a_w = 4'd9; immed_w = 16'h0000; flag_wr_w = 1'b1;
        tick();
        flag_wr_w = 1'b0;
        chk("w_flags_clr", {30'd0, carry_w, zero_w}, 32'd0);
        rs_a_w = 4'd10;
        #1;
        chk("w_r10_pre", {16'd0, rs_o_w}, 32'h1234);
        rs_a_w = 4'd9; immed_w = 16'h0100; rd_a_w = 4'd10; mul_start_w = 1'b1;
        tick();
        mul_start_w = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("w_mul_done_at", {31'd0, done_w}, {31'd0, (k == 16)});
        end
        tick();
        chk("w_mul_done_clr", {31'd0, done_w}, 32'd0);
        rs_a_w = 4'd10;
        #1;
        chk("w_mul_result", {16'd0, rs_o_w}, 32'h0000);
        chk("w_mul_carry", {31'd0, carry_w}, 32'd1);
        chk("w_mul_zero", {31'd0, zero_w}, 32'd1);
        rs_a_w = 4'd15;
        #1;
        chk("w_r15", {16'd0, rs_o_w}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
